// File: rtl/battleship_turn_sequencer.sv
// Game-flow controller for VGA Battleship: ship placement, alternating
// player/PC turns, player turn timer and win/lose detection.
//
// state     | meaning
// ----------+-------------------------------------------------
// S_IDLE    | no game in progress, waiting for start
// S_PLACE   | player committing ships onto the board
// S_PLAYER  | player aiming/firing, turn timer running
// S_PC      | waiting for the PC move generator to fire
// S_VICTORY | all PC ships sunk, counters frozen until start
// S_DEFEAT  | all player ships sunk, counters frozen until start
module battleship_turn_sequencer #(
   parameter int TICKS_PER_SEC = 1000,
   parameter int TURN_SECONDS  = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       start,
   input  logic [2:0] amount_of_ships,
   input  logic       player_place_ship,
   input  logic       player_move,
   input  logic       shot_hit,
   input  logic       pc_ack,
   input  logic       pc_hit,
   output logic       placing_ships,
   output logic       player_turn,
   output logic       pc_turn,
   output logic       pc_req,
   output logic       is_victory,
   output logic       is_defeat,
   output logic [2:0] ships_placed,
   output logic [2:0] player_ships_left,
   output logic [2:0] pc_ships_left,
   output logic [3:0] time_left,
   output logic       time_expired
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_PLACE   = 3'd1;
   localparam logic [2:0] S_PLAYER  = 3'd2;
   localparam logic [2:0] S_PC      = 3'd3;
   localparam logic [2:0] S_VICTORY = 3'd4;
   localparam logic [2:0] S_DEFEAT  = 3'd5;

   localparam int         PW        = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [PW-1:0] PS_LAST = PW'(TICKS_PER_SEC - 1);
   localparam logic [3:0] TURN_LOAD = 4'(TURN_SECONDS);

   logic [2:0]    state;
   logic [2:0]    ship_n;
   logic [2:0]    n_clamped;
   logic [PW-1:0] prescaler;
   logic [2:0]    pc_left_dec;
   logic [2:0]    player_left_dec;

   // Clamp requested ship count to 1..5 and form saturating decrements
   always_comb begin
      n_clamped = amount_of_ships;
      if (amount_of_ships == 3'd0)
         n_clamped = 3'd1;
      else if (amount_of_ships > 3'd5)
         n_clamped = 3'd5;
      pc_left_dec     = (pc_ships_left == 3'd0)     ? 3'd0 : pc_ships_left - 3'd1;
      player_left_dec = (player_ships_left == 3'd0) ? 3'd0 : player_ships_left - 3'd1;
   end

   // Moore flag decode from registered state
   always_comb begin
      placing_ships = (state == S_PLACE);
      player_turn   = (state == S_PLAYER);
      pc_turn       = (state == S_PC);
      pc_req        = (state == S_PC);
      is_victory    = (state == S_VICTORY);
      is_defeat     = (state == S_DEFEAT);
   end

   // Game sequencing, counters and player turn timer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state             <= S_IDLE;
         ship_n            <= 3'd0;
         ships_placed      <= 3'd0;
         player_ships_left <= 3'd0;
         pc_ships_left     <= 3'd0;
         time_left         <= 4'd0;
         prescaler         <= '0;
         time_expired      <= 1'b0;
      end else begin
         time_expired <= 1'b0;
         case (state)
            S_IDLE, S_VICTORY, S_DEFEAT: begin
               if (start) begin
                  ship_n            <= n_clamped;
                  ships_placed      <= 3'd0;
                  player_ships_left <= n_clamped;
                  pc_ships_left     <= n_clamped;
                  state             <= S_PLACE;
               end
            end
            S_PLACE: begin
               if (player_place_ship) begin
                  if (ships_placed + 3'd1 >= ship_n) begin
                     ships_placed <= ship_n;
                     time_left    <= TURN_LOAD;
                     prescaler    <= '0;
                     state        <= S_PLAYER;
                  end else begin
                     ships_placed <= ships_placed + 3'd1;
                  end
               end
            end
            S_PLAYER: begin
               // a move in the same cycle as the timeout tick takes priority
               if (player_move) begin
                  if (shot_hit) begin
                     pc_ships_left <= pc_left_dec;
                     state         <= (pc_left_dec == 3'd0) ? S_VICTORY : S_PC;
                  end else begin
                     state <= S_PC;
                  end
               end else if (tick) begin
                  if (prescaler == PS_LAST) begin
                     prescaler <= '0;
                     if (time_left == 4'd1) begin
                        time_left    <= 4'd0;
                        time_expired <= 1'b1;
                        state        <= S_PC;
                     end else begin
                        time_left <= time_left - 4'd1;
                     end
                  end else begin
                     prescaler <= prescaler + PW'(1);
                  end
               end
            end
            S_PC: begin
               if (pc_ack) begin
                  if (pc_hit) begin
                     player_ships_left <= player_left_dec;
                     if (player_left_dec == 3'd0) begin
                        state <= S_DEFEAT;
                     end else begin
                        time_left <= TURN_LOAD;
                        prescaler <= '0;
                        state     <= S_PLAYER;
                     end
                  end else begin
                     time_left <= TURN_LOAD;
                     prescaler <= '0;
                     state     <= S_PLAYER;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_battleship_turn_sequencer.sv
// Bench for battleship_turn_sequencer: directed game scenarios plus a
// randomized run checked against a turn-level reference model.
module tb_battleship_turn_sequencer;

   localparam int TPS = 4;
   localparam int TS  = 2;

   localparam int PH_IDLE = 0, PH_PLACE = 1, PH_PLAYER = 2, PH_PC = 3, PH_VIC = 4, PH_DEF = 5;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tick = 1'b0;
   logic       start = 1'b0;
   logic [2:0] amount_of_ships = 3'd0;
   logic       player_place_ship = 1'b0;
   logic       player_move = 1'b0;
   logic       shot_hit = 1'b0;
   logic       pc_ack = 1'b0;
   logic       pc_hit = 1'b0;
   logic       placing_ships, player_turn, pc_turn, pc_req, is_victory, is_defeat;
   logic [2:0] ships_placed, player_ships_left, pc_ships_left;
   logic [3:0] time_left;
   logic       time_expired;

   int tests = 0;
   int fails = 0;

   // turn-level reference model
   int m_phase, m_n, m_placed, m_pleft, m_cleft, m_tleft, m_turn_ticks;
   bit m_exp;

   battleship_turn_sequencer #(.TICKS_PER_SEC(TPS), .TURN_SECONDS(TS)) dut (
      .clk(clk), .rst(rst), .tick(tick), .start(start),
      .amount_of_ships(amount_of_ships), .player_place_ship(player_place_ship),
      .player_move(player_move), .shot_hit(shot_hit), .pc_ack(pc_ack), .pc_hit(pc_hit),
      .placing_ships(placing_ships), .player_turn(player_turn), .pc_turn(pc_turn),
      .pc_req(pc_req), .is_victory(is_victory), .is_defeat(is_defeat),
      .ships_placed(ships_placed), .player_ships_left(player_ships_left),
      .pc_ships_left(pc_ships_left), .time_left(time_left), .time_expired(time_expired)
   );

   always #5 clk = ~clk;

   wire [19:0] obs = {placing_ships, player_turn, pc_turn, pc_req, is_victory, is_defeat,
                      ships_placed, player_ships_left, pc_ships_left, time_left, time_expired};

   function automatic logic [19:0] model_vec();
      return {m_phase == PH_PLACE, m_phase == PH_PLAYER, m_phase == PH_PC, m_phase == PH_PC,
              m_phase == PH_VIC, m_phase == PH_DEF, 3'(m_placed), 3'(m_pleft), 3'(m_cleft),
              4'(m_tleft), m_exp};
   endfunction

   task automatic model_reset();
      m_phase = PH_IDLE; m_n = 0; m_placed = 0; m_pleft = 0; m_cleft = 0;
      m_tleft = 0; m_turn_ticks = 0; m_exp = 0;
   endtask

   task automatic begin_player_turn();
      m_phase = PH_PLAYER; m_turn_ticks = 0; m_tleft = TS;
   endtask

   // advance the model by one clock using the currently driven inputs
   task automatic model_step();
      m_exp = 0;
      case (m_phase)
         PH_IDLE, PH_VIC, PH_DEF:
            if (start) begin
               m_n = (amount_of_ships < 1) ? 1 : (amount_of_ships > 5) ? 5 : int'(amount_of_ships);
               m_placed = 0; m_pleft = m_n; m_cleft = m_n; m_phase = PH_PLACE;
            end
         PH_PLACE:
            if (player_place_ship) begin
               m_placed++;
               if (m_placed == m_n) begin_player_turn();
            end
         PH_PLAYER:
            if (player_move) begin
               if (shot_hit) begin
                  if (m_cleft > 0) m_cleft--;
                  m_phase = (m_cleft == 0) ? PH_VIC : PH_PC;
               end else m_phase = PH_PC;
            end else if (tick) begin
               m_turn_ticks++;
               if (m_turn_ticks == TS * TPS) begin
                  m_exp = 1; m_tleft = 0; m_phase = PH_PC;
               end else m_tleft = TS - m_turn_ticks / TPS;
            end
         PH_PC:
            if (pc_ack) begin
               if (pc_hit && m_pleft > 0) m_pleft--;
               if (m_pleft == 0) m_phase = PH_DEF;
               else begin_player_turn();
            end
         default: ;
      endcase
   endtask

   // one clock: model follows inputs, pulses drop after the edge
   task automatic step();
      model_step();
      @(posedge clk); #1;
      tick = 0; start = 0; player_place_ship = 0; player_move = 0; shot_hit = 0;
      pc_ack = 0; pc_hit = 0;
   endtask

   task automatic do_reset();
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
      model_reset();
   endtask

   task automatic test_reset();
      do_reset();
      tests++; if (obs !== 20'd0) begin fails++; $display("FAIL reset_idle obs=%h exp=%h", obs, 20'd0); end
      start = 1; amount_of_ships = 3'd3; step();
      repeat (3) begin player_place_ship = 1; step(); end
      tick = 1; step();
      tests++; if (player_turn !== 1'b1 || time_left !== 4'(TS)) begin
         fails++; $display("FAIL reset_setup player_turn=%b time_left=%0d exp 1/%0d", player_turn, time_left, TS);
      end
      #2 rst = 1;
      #1;
      tests++; if (obs !== 20'd0) begin fails++; $display("FAIL reset_async obs=%h exp=%h", obs, 20'd0); end
      @(posedge clk); #1;
      rst = 0;
      model_reset();
      tests++; if (obs !== 20'd0) begin fails++; $display("FAIL reset_hold obs=%h exp=%h", obs, 20'd0); end
   endtask

   task automatic test_clamp_place();
      do_reset();
      start = 1; amount_of_ships = 3'd0; step();
      tests++; if (placing_ships !== 1'b1 || pc_ships_left !== 3'd1 || player_ships_left !== 3'd1) begin
         fails++; $display("FAIL clamp0_start placing=%b pc_left=%0d pl_left=%0d exp 1/1/1", placing_ships, pc_ships_left, player_ships_left);
      end
      player_place_ship = 1; step();
      tests++; if (ships_placed !== 3'd1 || player_turn !== 1'b1) begin
         fails++; $display("FAIL clamp0_place placed=%0d player_turn=%b exp 1/1", ships_placed, player_turn);
      end
      do_reset();
      start = 1; amount_of_ships = 3'd7; step();
      repeat (4) begin player_place_ship = 1; step(); end
      tests++; if (ships_placed !== 3'd4 || placing_ships !== 1'b1) begin
         fails++; $display("FAIL clamp7_four placed=%0d placing=%b exp 4/1", ships_placed, placing_ships);
      end
      player_place_ship = 1; step();
      tests++; if (ships_placed !== 3'd5 || player_turn !== 1'b1 || pc_ships_left !== 3'd5) begin
         fails++; $display("FAIL clamp7_five placed=%0d player_turn=%b pc_left=%0d exp 5/1/5", ships_placed, player_turn, pc_ships_left);
      end
   endtask

   task automatic test_victory();
      do_reset();
      start = 1; amount_of_ships = 3'd2; step();
      repeat (2) begin player_place_ship = 1; step(); end
      player_move = 1; shot_hit = 1; step();
      tests++; if (pc_ships_left !== 3'd1 || pc_turn !== 1'b1) begin
         fails++; $display("FAIL vic_hit1 pc_left=%0d pc_turn=%b exp 1/1", pc_ships_left, pc_turn);
      end
      pc_ack = 1; pc_hit = 0; step();
      player_move = 1; shot_hit = 1; step();
      tests++; if (pc_ships_left !== 3'd0 || is_victory !== 1'b1 || player_ships_left !== 3'd2) begin
         fails++; $display("FAIL vic_hit2 pc_left=%0d victory=%b pl_left=%0d exp 0/1/2", pc_ships_left, is_victory, player_ships_left);
      end
      player_move = 1; shot_hit = 1; step();
      pc_ack = 1; pc_hit = 1; step();
      tests++; if (obs !== model_vec() || is_victory !== 1'b1) begin
         fails++; $display("FAIL vic_hold obs=%h exp=%h", obs, model_vec());
      end
   endtask

   task automatic test_defeat();
      do_reset();
      start = 1; amount_of_ships = 3'd1; step();
      player_place_ship = 1; step();
      player_move = 1; shot_hit = 0; step();
      tests++; if (pc_req !== 1'b1 || pc_ships_left !== 3'd1) begin
         fails++; $display("FAIL def_miss pc_req=%b pc_left=%0d exp 1/1", pc_req, pc_ships_left);
      end
      pc_ack = 1; pc_hit = 1; step();
      tests++; if (player_ships_left !== 3'd0 || is_defeat !== 1'b1 || pc_req !== 1'b0) begin
         fails++; $display("FAIL def_end pl_left=%0d defeat=%b pc_req=%b exp 0/1/0", player_ships_left, is_defeat, pc_req);
      end
   endtask

   task automatic test_timeout();
      do_reset();
      start = 1; amount_of_ships = 3'd1; step();
      player_place_ship = 1; step();
      tests++; if (time_left !== 4'd2) begin fails++; $display("FAIL to_load time_left=%0d exp 2", time_left); end
      repeat (4) begin tick = 1; step(); end
      tests++; if (time_left !== 4'd1 || player_turn !== 1'b1) begin
         fails++; $display("FAIL to_sec1 time_left=%0d player_turn=%b exp 1/1", time_left, player_turn);
      end
      repeat (3) begin tick = 1; step(); end
      tests++; if (time_expired !== 1'b0 || player_turn !== 1'b1) begin
         fails++; $display("FAIL to_tick7 expired=%b player_turn=%b exp 0/1", time_expired, player_turn);
      end
      tick = 1; step();
      tests++; if (time_expired !== 1'b1 || pc_turn !== 1'b1 || time_left !== 4'd0 || pc_ships_left !== 3'd1) begin
         fails++; $display("FAIL to_tick8 expired=%b pc_turn=%b time_left=%0d pc_left=%0d exp 1/1/0/1", time_expired, pc_turn, time_left, pc_ships_left);
      end
      step();
      tests++; if (time_expired !== 1'b0 || pc_req !== 1'b1) begin
         fails++; $display("FAIL to_pulse expired=%b pc_req=%b exp 0/1", time_expired, pc_req);
      end
   endtask

   task automatic test_collision();
      do_reset();
      start = 1; amount_of_ships = 3'd2; step();
      repeat (2) begin player_place_ship = 1; step(); end
      repeat (7) begin tick = 1; step(); end
      tick = 1; player_move = 1; shot_hit = 1; step();
      tests++; if (time_expired !== 1'b0 || pc_turn !== 1'b1 || pc_ships_left !== 3'd1 || time_left !== 4'd1) begin
         fails++; $display("FAIL coll_move expired=%b pc_turn=%b pc_left=%0d time_left=%0d exp 0/1/1/1", time_expired, pc_turn, pc_ships_left, time_left);
      end
      start = 1; amount_of_ships = 3'd5; step();
      tests++; if (pc_turn !== 1'b1 || placing_ships !== 1'b0 || pc_ships_left !== 3'd1) begin
         fails++; $display("FAIL coll_start pc_turn=%b placing=%b pc_left=%0d exp 1/0/1", pc_turn, placing_ships, pc_ships_left);
      end
      pc_ack = 1; pc_hit = 0; step();
      tests++; if (player_turn !== 1'b1 || time_left !== 4'd2) begin
         fails++; $display("FAIL coll_reload player_turn=%b time_left=%0d exp 1/2", player_turn, time_left);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         tick              = ($urandom_range(0, 1) == 0);
         start             = ($urandom_range(0, 15) == 0);
         amount_of_ships   = 3'($urandom_range(0, 7));
         player_place_ship = ($urandom_range(0, 2) == 0);
         player_move       = ($urandom_range(0, 15) == 0);
         shot_hit          = ($urandom_range(0, 1) == 0);
         pc_ack            = ($urandom_range(0, 3) == 0);
         pc_hit            = ($urandom_range(0, 2) == 0);
         step();
         tests++;
         if (obs !== model_vec()) begin
            fails++;
            $display("FAIL random cyc=%0d obs=%h exp=%h", i, obs, model_vec());
         end
      end
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_clamp_place();
      test_victory();
      test_defeat();
      test_timeout();
      test_collision();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
